// File: rtl/halfband_decim2.sv
// halfband_decim2: 2:1 decimating half-band FIR with folded symmetric taps and a free-running pipeline.
// Optional macro HB_COEF_LOAD_EN adds run-time loadable side coefficients (coef_wr/coef_addr/coef_data).
module halfband_decim2 #(
  parameter int WIDTH = 18,
  parameter int NTAPS = 15,
  parameter int CW = 18,
  parameter logic [((NTAPS+1)/4)*CW-1:0] COEF_INIT = {-18'sd348, 18'sd3274, -18'sd15925, 18'sd78535}
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] x_in,
`ifdef HB_COEF_LOAD_EN
  input  logic                    coef_wr,
  input  logic [$clog2((NTAPS+1)/4)-1:0] coef_addr,
  input  logic signed [CW-1:0]    coef_data,
`endif
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] y
);

  localparam int NU  = (NTAPS + 1) / 4;
  localparam int CTR = (NTAPS - 1) / 2;
  localparam int L   = $clog2(NU + 1);
  localparam int TN  = 1 << L;
  localparam int FW  = WIDTH + 1;
  localparam int PW  = WIDTH + 1 + CW;
  localparam int AW  = PW + L;

  localparam logic signed [AW-1:0] RND  = {{(AW-CW){1'b0}}, 1'b1, {(CW-1){1'b0}}};
  localparam logic signed [AW-1:0] YMAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] YMIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  function automatic logic signed [WIDTH-1:0] round_sat(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] r;
    r = (acc + RND) >>> CW;
    if (r > YMAX) return YMAX[WIDTH-1:0];
    if (r < YMIN) return YMIN[WIDTH-1:0];
    return r[WIDTH-1:0];
  endfunction

  logic signed [WIDTH-1:0] dl [NTAPS];
  logic                    phase;
  logic signed [CW-1:0]    coef_cur [NU];
  logic signed [CW-1:0]    coef_p0 [NU];
  logic signed [CW-1:0]    coef_p1 [NU];
  logic signed [FW-1:0]    fold_p1 [NU];
  logic signed [WIDTH-1:0] ctr_p1;
  logic signed [PW-1:0]    prod_p2 [NU];
  logic signed [PW-1:0]    ctr_p2;
  logic signed [AW-1:0]    lvl0 [TN];
  logic signed [AW-1:0]    tree_p [L][TN];
  logic                    vld_p0, vld_p1, vld_p2;
  logic [L-1:0]            vld_tree_p;

`ifdef HB_COEF_LOAD_EN
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NU; k++) coef_cur[k] <= COEF_INIT[(NU-1-k)*CW +: CW];
    end else if (coef_wr && (int'(coef_addr) < NU)) begin
      coef_cur[coef_addr] <= coef_data;
    end
  end
`else
  always_comb begin
    for (int k = 0; k < NU; k++) coef_cur[k] = COEF_INIT[(NU-1-k)*CW +: CW];
  end
`endif

  // Control: phase and valid flags; clear flushes every in-flight launch.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset || clear) begin
      phase      <= 1'b0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      vld_tree_p <= '0;
      out_valid  <= 1'b0;
    end else begin
      vld_p0 <= in_valid & phase;
      if (in_valid) phase <= ~phase;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      vld_tree_p[0] <= vld_p2;
      for (int l = 1; l < L; l++) vld_tree_p[l] <= vld_tree_p[l-1];
      out_valid <= vld_tree_p[L-1];
    end
  end

  // Stage p0: delay line, newest sample at index 0.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset || clear) begin
      for (int i = 0; i < NTAPS; i++) dl[i] <= '0;
    end else if (in_valid) begin
      dl[0] <= x_in;
      for (int i = 1; i < NTAPS; i++) dl[i] <= dl[i-1];
    end
  end

  always_comb begin
    for (int i = 0; i < TN; i++) lvl0[i] = '0;
    for (int j = 0; j < NU; j++) lvl0[j] = AW'(prod_p2[j]);
    lvl0[NU] = AW'(ctr_p2);
  end

  // Coefficients travel with the data so a mid-pipeline load cannot touch earlier launches.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < NU; j++) begin
        coef_p0[j] <= '0;
        coef_p1[j] <= '0;
        fold_p1[j] <= '0;
        prod_p2[j] <= '0;
      end
      ctr_p1 <= '0;
      ctr_p2 <= '0;
      for (int l = 0; l < L; l++)
        for (int i = 0; i < TN; i++) tree_p[l][i] <= '0;
    end else begin
      for (int j = 0; j < NU; j++) begin
        coef_p0[j] <= coef_cur[j];
        coef_p1[j] <= coef_p0[j];
        fold_p1[j] <= FW'(dl[2*j]) + FW'(dl[NTAPS-1-2*j]);
        prod_p2[j] <= PW'(fold_p1[j]) * PW'(coef_p1[j]);
      end
      ctr_p1 <= dl[CTR];
      ctr_p2 <= PW'(ctr_p1) <<< (CW - 1);
      for (int i = 0; i < TN/2; i++) begin
        tree_p[0][i]        <= lvl0[2*i] + lvl0[2*i+1];
        tree_p[0][i + TN/2] <= '0;
      end
      for (int l = 1; l < L; l++) begin
        for (int i = 0; i < TN/2; i++) begin
          tree_p[l][i]        <= tree_p[l-1][2*i] + tree_p[l-1][2*i+1];
          tree_p[l][i + TN/2] <= '0;
        end
      end
    end
  end

  // Output stage: y updates only with a surviving launch.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      y <= '0;
    end else if (!clear && vld_tree_p[L-1]) begin
      y <= round_sat(tree_p[L-1][0]);
    end
  end

endmodule

// File: tb/tb_halfband_decim2.sv
// Directed bench for halfband_decim2: impulse/constant/saturation/rounding responses, clear, async reset.
module tb_halfband_decim2;
  localparam int WIDTH = 18;

  logic sys_clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic signed [WIDTH-1:0] x_in = '0;
`ifdef HB_COEF_LOAD_EN
  logic coef_wr = 1'b0;
  logic [1:0] coef_addr = '0;
  logic signed [17:0] coef_data = '0;
`endif
  logic out_valid;
  logic signed [WIDTH-1:0] y;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int yq[$];
  int tq[$];
  int exp_q[$];
  int e;
  int found;

  halfband_decim2 dut (
    .sys_clk(sys_clk),
    .reset(reset),
    .clear(clear),
    .in_valid(in_valid),
    .x_in(x_in),
`ifdef HB_COEF_LOAD_EN
    .coef_wr(coef_wr),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
`endif
    .out_valid(out_valid),
    .y(y)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;
  always @(negedge sys_clk) begin
    if (out_valid) begin
      yq.push_back(int'(y));
      tq.push_back(cyc);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_seq(input string tag);
    int v;
    check({tag, "_count"}, yq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      v = (i < yq.size()) ? yq[i] : -999999;
      check($sformatf("%s[%0d]", tag, i), v, exp_q[i]);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input int x);
    in_valid = 1'b1;
    x_in = WIDTH'(x);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send(0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic flush_q();
    yq.delete();
    tq.delete();
  endtask

  initial begin
    // reset state, asynchronous
    #2;
    check("rst_y", int'(y), 0);
    check("rst_out_valid", int'(out_valid), 0);
    repeat (2) @(posedge sys_clk);
    #1 reset = 1'b0;

    // impulse as 1st sample: centre tap only, first result 6 cycles after 2nd sample
    flush_q();
    send(65536);
    send(0);
    e = cyc;
    send_zeros(13);
    repeat (12) tick();
    exp_q = {0, 0, 0, 32768, 0, 0, 0};
    check_seq("imp1st");
    check("imp1st_latency", (tq.size() > 0) ? tq[0] : -1, e + 6);
    check("imp1st_spacing", (tq.size() > 1) ? tq[1] - tq[0] : -1, 2);

    // rounding half-up at the centre tap
    do_clear(); flush_q();
    send(1); send_zeros(13); repeat (12) tick();
    check("round_p0p5", (yq.size() > 3) ? yq[3] : -999999, 1);
    do_clear(); flush_q();
    send(-1); send_zeros(13); repeat (12) tick();
    check("round_m0p5", (yq.size() > 3) ? yq[3] : -999999, 0);
    do_clear(); flush_q();
    send(-3); send_zeros(13); repeat (12) tick();
    check("round_m1p5", (yq.size() > 3) ? yq[3] : -999999, -1);

    // impulse as 2nd sample: side taps in order
    do_clear(); flush_q();
    send(0); send(65536); send_zeros(14);
    repeat (12) tick();
    exp_q = {-87, 819, -3981, 19634, 19634, -3981, 819, -87};
    check_seq("imp2nd");
    check("hold_y", int'(y), -87);
    check("hold_out_valid", int'(out_valid), 0);

    // clear 2 cycles after launch, colliding with an input sample
    do_clear(); flush_q();
    send(0); send(65536); send(0);
    clear = 1'b1; in_valid = 1'b1; x_in = WIDTH'(12345);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    repeat (10) tick();
    check("clear_no_out", yq.size(), 0);
    check("clear_hold_y", int'(y), -87);
    flush_q();
    send(65536); send_zeros(13);
    repeat (12) tick();
    exp_q = {0, 0, 0, 32768, 0, 0, 0};
    check_seq("after_clear");

    // constant full-scale inputs, back-to-back
    do_clear(); flush_q();
    for (int i = 0; i < 30; i++) send(131071);
    repeat (12) tick();
    check("dc_pos_count", yq.size(), 15);
    check("dc_pos_a", (yq.size() > 10) ? yq[10] : -999999, 131071);
    check("dc_pos_b", (yq.size() > 14) ? yq[14] : -999999, 131071);
    check("dc_pos_spacing", (tq.size() > 14) ? tq[14] - tq[13] : -1, 2);
    do_clear(); flush_q();
    for (int i = 0; i < 30; i++) send(-131072);
    repeat (12) tick();
    check("dc_neg", (yq.size() > 14) ? yq[14] : -999999, -131072);

    // sign-matched pattern drives the accumulator past full scale
    do_clear(); flush_q();
    send(0);
    for (int i = 1; i <= 15; i++) begin
      int k;
      k = 15 - i;
      send((k == 0 || k == 4 || k == 10 || k == 14) ? -131072 : 131071);
    end
    repeat (12) tick();
    check("sat_pos", (yq.size() > 7) ? yq[7] : -999999, 131071);
    do_clear(); flush_q();
    send(0);
    for (int i = 1; i <= 15; i++) begin
      int k;
      k = 15 - i;
      send((k == 0 || k == 4 || k == 10 || k == 14) ? 131071 : -131072);
    end
    repeat (12) tick();
    check("sat_neg", (yq.size() > 7) ? yq[7] : -999999, -131072);

    // reset asserted between edges while results are streaming
    do_clear(); flush_q();
    in_valid = 1'b1; x_in = WIDTH'(131071);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      if (out_valid) found = 1;
    end
    check("midrst_stream_seen", found, 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_y", int'(y), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    check("midrst_y_after", int'(y), 0);

    // first edge after release accepts data
    flush_q();
    send(0); send(65536);
    e = cyc;
    send_zeros(14);
    repeat (12) tick();
    check("post_rst_first", (yq.size() > 0) ? yq[0] : -999999, -87);
    check("post_rst_peak", (yq.size() > 3) ? yq[3] : -999999, 19634);
    check("post_rst_latency", (tq.size() > 0) ? tq[0] : -1, e + 6);

`ifdef HB_COEF_LOAD_EN
    coef_wr = 1'b1; coef_addr = 2'd3; coef_data = 18'sd131071;
    tick();
    coef_wr = 1'b0;
    do_clear(); flush_q();
    for (int i = 0; i < 30; i++) send(65536);
    repeat (12) tick();
    check("coef_load_half", (yq.size() > 14) ? yq[14] : -999999, 91804);
    do_clear(); flush_q();
    for (int i = 0; i < 30; i++) send(131071);
    repeat (12) tick();
    check("coef_load_sat", (yq.size() > 14) ? yq[14] : -999999, 131071);
    #2 reset = 1'b1;
    tick();
    reset = 1'b0;
    flush_q();
    send(0); send(65536); send_zeros(14);
    repeat (12) tick();
    exp_q = {-87, 819, -3981, 19634, 19634, -3981, 819, -87};
    check_seq("coef_restored");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
